reg_alu_sequencer: RTL and testbench
====================================

# reg_alu_sequencer

Multi-cycle command sequencer that drives the register-file/ALU datapath: it issues read addresses, ALU operation and write-enable, then returns the result and flags to a host over a valid/ready response channel. It sits upstream of the register file and ALU, whose `W_Data` is wired to ALU `F`. The block is the initiator for the datapath, which answers combinationally. A repeat count lets one command run the same operation N+1 times, for example to build constants by repeated increment.

## Interface
- `REPEAT_W`, default 4: width of the repeat-count field.
- `clk`  in  1: clock, rising edge.
- `Reset`  in  1: asynchronous, active-low reset.
- `cmd_valid`  in  1: command offered.
- `cmd_ready`  out  1: sequencer can accept a command.
- `cmd_op`  in  3: ALU operation code (0 and, 1 or, 2 xor, 3 inc, 4 add, 5 sub, 6 slt, 7 sll).
- `cmd_rd`, `cmd_rs`, `cmd_rt`  in  5 each: write, A and B register addresses.
- `cmd_nowb`  in  1: compute only; `Write_Reg` is never asserted.
- `cmd_count`  in  REPEAT_W: extra iterations; total iterations = `cmd_count` + 1.
- `rsp_valid`  out  1: result available.
- `rsp_ready`  in  1: host consumes result.
- `rsp_f`  out  32: last captured F.
- `rsp_zf`  out  1: ZF of last iteration.
- `rsp_of`  out  1: OR of OF over all iterations.
- `R_Addr_A`, `R_Addr_B`, `W_Addr`  out  5 each: register-file addresses.
- `ALU_OP`  out  3: ALU operation.
- `Write_Reg`  out  1: register-file write enable.
- `F`  in  32; `ZF`, `OF`  in  1 each: ALU results.

## Operation
- States: IDLE, ISSUE, WB, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`: latch all command fields, load the iteration counter with `cmd_count`, clear sticky OF, go to ISSUE.
- ISSUE: drive latched addresses and `ALU_OP`; `Write_Reg`=0; the ALU settles; go to WB.
- WB:
  - Addresses and `ALU_OP` are unchanged from ISSUE, so `F` is stable while it is being written.
  - `Write_Reg` = !nowb.
  - At the closing edge: capture `F` into `rsp_f` and `ZF` into `rsp_zf`; OR `OF` into `rsp_of`.
  - If counter ≠ 0: decrement and return to ISSUE. If counter = 0: go to RESP.
- RESP: `rsp_valid`=1 with stable data until `rsp_valid & rsp_ready`, then go to IDLE.
- `cmd_ready` = (state == IDLE) only; a command and a response never overlap.
- Counter arithmetic: unsigned, REPEAT_W bits. `cmd_count` = 2^REPEAT_W−1 gives 2^REPEAT_W iterations; the counter never wraps.
- `rd` = `rs` repeats (read-modify-write) are legal: each iteration re-reads the value written in the previous WB.
- Reset (Reset=0, at any time, including mid-WB):
  - State goes to IDLE.
  - All outputs become 0, except `cmd_ready`, which is 0 while Reset is low and 1 from the first cycle after release.
  - `Write_Reg` drops immediately without waiting for a clock edge.
  - A partially executed command is discarded, with no response.

## Timing
- All outputs are registered state or decoded directly from state; there is no combinational path from a `cmd_*` input to any output.
- Acceptance edge is e0. ISSUE is the cycle after e0; WB follows it.
- Each iteration takes 2 cycles. `rsp_valid` first rises 2·(`cmd_count`+1) cycles after e0.
- `Write_Reg` is high for exactly one cycle per iteration, in WB.
- Minimum command-to-command spacing is 2·(N+1)+2 cycles with `rsp_ready` held high.
- `rsp_ready` high in the first RESP cycle: `cmd_ready` rises on the next cycle.

## Structure
- Shared package `alu_pkg`:
  - ALU opcode constants (`OP_AND` … `OP_SLL`), shared with the ALU.
  - State enum for this block.
- No sub-module: a single FSM plus counter. The top level instantiates this block alongside the existing register file and ALU.

## Test plan
- Reset release, then cmd inc rd=rs=1, count=4: exactly 5 `Write_Reg` pulses; `rsp_f`=5, `rsp_zf`=0, `rsp_of`=0; r1=5.
- Then add rd=2, rs=rt=1, count=0: `rsp_valid` 2 cycles after acceptance; `rsp_f`=10; r2=10.
- sub rd=3, rs=rt=1, nowb=1: `Write_Reg` never high; `rsp_f`=0, `rsp_zf`=1; r3 unchanged.
- sll rd=4, rs=1 (A=5), rt=2 (B=10): `rsp_f`=320.
- `rsp_ready` held low 3 cycles in RESP: `rsp_*` stable, `cmd_ready`=0, and a new `cmd_valid` is ignored until the handshake.
- Reset asserted mid-WB of a count=3 inc: `Write_Reg` drops before the next edge; no response; `cmd_ready`=1 after release; the target register holds only the completed writes.

Source files
------------

// File: rtl/alu_pkg.sv
// Opcodes shared by the ALU and the command sequencer, and the sequencer state encoding.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_INC = 3'd3;
    localparam logic [2:0] OP_ADD = 3'd4;
    localparam logic [2:0] OP_SUB = 3'd5;
    localparam logic [2:0] OP_SLT = 3'd6;
    localparam logic [2:0] OP_SLL = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WB,
        S_RESP
    } seq_state_t;

endpackage

// File: rtl/reg_alu_sequencer.sv
// Command sequencer for the register-file/ALU datapath: issues reads, writes F back,
// repeats the operation cmd_count+1 times and returns the last F plus flags to the host.
module reg_alu_sequencer
    import alu_pkg::*;
#(
    parameter int REPEAT_W = 4
) (
    input  logic                clk,
    input  logic                Reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic [4:0]          cmd_rd,
    input  logic [4:0]          cmd_rs,
    input  logic [4:0]          cmd_rt,
    input  logic                cmd_nowb,
    input  logic [REPEAT_W-1:0] cmd_count,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [31:0]         rsp_f,
    output logic                rsp_zf,
    output logic                rsp_of,
    output logic [4:0]          R_Addr_A,
    output logic [4:0]          R_Addr_B,
    output logic [4:0]          W_Addr,
    output logic [2:0]          ALU_OP,
    output logic                Write_Reg,
    input  logic [31:0]         F,
    input  logic                ZF,
    input  logic                OF
);

    seq_state_t          r_state;
    logic [REPEAT_W-1:0] r_cnt;
    logic                r_nowb;
    logic                r_cmd_ready;
    logic                r_rsp_valid;
    logic [31:0]         r_rsp_f;
    logic                r_rsp_zf;
    logic                r_rsp_of;
    logic [4:0]          r_ra;
    logic [4:0]          r_rb;
    logic [4:0]          r_wa;
    logic [2:0]          r_op;
    logic                r_write_reg;
    logic                w_accept;

    // cmd_ready is registered, so acceptance only happens once the host has actually seen it high
    assign w_accept = cmd_valid & r_cmd_ready;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_nowb      <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_f     <= '0;
            r_rsp_zf    <= 1'b0;
            r_rsp_of    <= 1'b0;
            r_ra        <= '0;
            r_rb        <= '0;
            r_wa        <= '0;
            r_op        <= '0;
            r_write_reg <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_accept) begin
                        r_ra        <= cmd_rs;
                        r_rb        <= cmd_rt;
                        r_wa        <= cmd_rd;
                        r_op        <= cmd_op;
                        r_nowb      <= cmd_nowb;
                        r_cnt       <= cmd_count;
                        r_rsp_of    <= 1'b0;
                        r_cmd_ready <= 1'b0;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // addresses are already stable; the write strobe lands in WB while F holds
                    r_write_reg <= ~r_nowb;
                    r_state     <= S_WB;
                end
                S_WB: begin
                    r_write_reg <= 1'b0;
                    r_rsp_f     <= F;
                    r_rsp_zf    <= ZF;
                    r_rsp_of    <= r_rsp_of | OF;
                    if (r_cnt != '0) begin
                        r_cnt   <= r_cnt - 1'b1;
                        r_state <= S_ISSUE;
                    end else begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_f     = r_rsp_f;
    assign rsp_zf    = r_rsp_zf;
    assign rsp_of    = r_rsp_of;
    assign R_Addr_A  = r_ra;
    assign R_Addr_B  = r_rb;
    assign W_Addr    = r_wa;
    assign ALU_OP    = r_op;
    assign Write_Reg = r_write_reg;

endmodule

// File: tb/tb_reg_alu_sequencer.sv
// Bench for reg_alu_sequencer: a behavioural register file and ALU answer the sequencer,
// and each response is compared with an iteration-level model of the command.
module tb_reg_alu_sequencer;

    localparam int REPEAT_W = 4;

    logic                clk = 1'b0;
    logic                Reset;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [2:0]          cmd_op;
    logic [4:0]          cmd_rd;
    logic [4:0]          cmd_rs;
    logic [4:0]          cmd_rt;
    logic                cmd_nowb;
    logic [REPEAT_W-1:0] cmd_count;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [31:0]         rsp_f;
    logic                rsp_zf;
    logic                rsp_of;
    logic [4:0]          R_Addr_A;
    logic [4:0]          R_Addr_B;
    logic [4:0]          W_Addr;
    logic [2:0]          ALU_OP;
    logic                Write_Reg;
    logic [31:0]         F;
    logic                ZF;
    logic                OF;

    logic [31:0] regs  [32] = '{default: 32'd0};
    logic [31:0] mregs [32] = '{default: 32'd0};
    logic        poke_en = 1'b0;
    logic [4:0]  poke_addr = '0;
    logic [31:0] poke_data = '0;
    int          wr_cnt = 0;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    reg_alu_sequencer #(.REPEAT_W(REPEAT_W)) dut (
        .clk(clk), .Reset(Reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
        .cmd_nowb(cmd_nowb), .cmd_count(cmd_count),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_f(rsp_f),
        .rsp_zf(rsp_zf), .rsp_of(rsp_of),
        .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B), .W_Addr(W_Addr),
        .ALU_OP(ALU_OP), .Write_Reg(Write_Reg),
        .F(F), .ZF(ZF), .OF(OF)
    );

    function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return a + 32'd1;
            3'd4:    return a + b;
            3'd5:    return a - b;
            3'd6:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return b << a[4:0];
        endcase
    endfunction

    function automatic logic alu_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s;
        s = alu_f(op, a, b);
        case (op)
            3'd3:    return (a == 32'h7fff_ffff);
            3'd4:    return (a[31] == b[31]) && (s[31] != a[31]);
            3'd5:    return (a[31] != b[31]) && (s[31] != a[31]);
            default: return 1'b0;
        endcase
    endfunction

    assign F  = alu_f(ALU_OP, regs[R_Addr_A], regs[R_Addr_B]);
    assign ZF = (F == 32'd0);
    assign OF = alu_of(ALU_OP, regs[R_Addr_A], regs[R_Addr_B]);

    always @(posedge clk) begin
        if (Write_Reg) begin
            regs[W_Addr] <= F;
            wr_cnt <= wr_cnt + 1;
        end
        if (poke_en) regs[poke_addr] <= poke_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [4:0] addr, input logic [31:0] data);
        poke_en = 1'b1; poke_addr = addr; poke_data = data;
        tick();
        poke_en = 1'b0;
        mregs[addr] = data;
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs,
                           input logic [4:0] rt, input logic nowb, input int count, input int hold);
        int waitc, lat, w0, w1;
        logic [31:0] a, b, ef, fh;
        logic eof;
        waitc = 0;
        while (cmd_ready !== 1'b1 && waitc < 50) begin tick(); waitc++; end
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt;
        cmd_nowb = nowb; cmd_count = REPEAT_W'(count);
        w0 = wr_cnt;
        tick();
        cmd_valid = 1'b0;
        check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 100) begin tick(); lat++; end
        check("latency", 32'(lat), 32'(2 * (count + 1)));
        ef = '0; eof = 1'b0;
        for (int i = 0; i <= count; i++) begin
            a = mregs[rs]; b = mregs[rt];
            ef = alu_f(op, a, b);
            eof = eof | alu_of(op, a, b);
            if (!nowb) mregs[rd] = ef;
        end
        check("rsp_f", rsp_f, ef);
        check("rsp_zf", 32'(rsp_zf), 32'(ef == 32'd0));
        check("rsp_of", 32'(rsp_of), 32'(eof));
        check("wr_pulses", 32'(wr_cnt - w0), nowb ? 32'd0 : 32'(count + 1));
        check("regfile_rd", regs[rd], mregs[rd]);
        fh = rsp_f;
        w1 = wr_cnt;
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1; cmd_op = 3'($urandom_range(0, 7));
            tick();
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_f", rsp_f, fh);
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("cmd_ready_after_rsp", 32'(cmd_ready), 32'd1);
        check("rsp_valid_after_rsp", 32'(rsp_valid), 32'd0);
        check("no_stray_writes", 32'(wr_cnt - w1), 32'd0);
    endtask

    initial begin
        Reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs = '0; cmd_rt = '0;
        cmd_nowb = 1'b0; cmd_count = '0; rsp_ready = 1'b0;
        tick(); tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_write_reg", 32'(Write_Reg), 32'd0);
        check("rst_rsp_f", rsp_f, 32'd0);
        check("rst_addr", {17'd0, R_Addr_A, R_Addr_B, W_Addr}, 32'd0);
        Reset = 1'b1;
        tick();
        check("ready_after_release", 32'(cmd_ready), 32'd1);

        run_cmd(3'd3, 5'd1, 5'd1, 5'd0, 1'b0, 4, 0);
        check("plan_inc_r1", regs[1], 32'd5);
        run_cmd(3'd4, 5'd2, 5'd1, 5'd1, 1'b0, 0, 0);
        check("plan_add_r2", regs[2], 32'd10);
        run_cmd(3'd5, 5'd3, 5'd1, 5'd1, 1'b1, 0, 0);
        check("plan_sub_zf", 32'(rsp_zf), 32'd1);
        check("plan_sub_r3", regs[3], 32'd0);
        run_cmd(3'd7, 5'd4, 5'd1, 5'd2, 1'b0, 0, 3);
        check("plan_sll_r4", regs[4], 32'd320);

        run_cmd(3'd3, 5'd7, 5'd7, 5'd0, 1'b0, 15, 0);
        check("max_count_r7", regs[7], 32'd16);
        poke(5'd8, 32'h7fff_ffff);
        poke(5'd9, 32'h0000_0001);
        run_cmd(3'd4, 5'd10, 5'd8, 5'd9, 1'b0, 1, 0);

        for (int k = 0; k < 16; k++) begin
            poke(5'($urandom_range(1, 9)), $urandom);
            run_cmd(3'($urandom_range(0, 7)), 5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)),
                    5'($urandom_range(0, 9)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        poke(5'd6, 32'd100);
        cmd_valid = 1'b1; cmd_op = 3'd3; cmd_rd = 5'd6; cmd_rs = 5'd6; cmd_rt = 5'd0;
        cmd_nowb = 1'b0; cmd_count = REPEAT_W'(3);
        tick();
        cmd_valid = 1'b0;
        tick(); tick(); tick();
        check("midwb_write_high", 32'(Write_Reg), 32'd1);
        #2 Reset = 1'b0;
        #1;
        check("async_write_drop", 32'(Write_Reg), 32'd0);
        check("async_cmd_ready", 32'(cmd_ready), 32'd0);
        check("async_alu_op", 32'(ALU_OP), 32'd0);
        check("async_rsp_valid", 32'(rsp_valid), 32'd0);
        tick(); tick();
        Reset = 1'b1;
        tick();
        check("ready_after_midwb_reset", 32'(cmd_ready), 32'd1);
        check("no_rsp_after_reset", 32'(rsp_valid), 32'd0);
        mregs[6] = 32'd101;
        check("partial_writes_r6", regs[6], mregs[6]);
        run_cmd(3'd2, 5'd11, 5'd6, 5'd1, 1'b0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
